inbuf_rd_sched: RTL
===================

Name: inbuf_rd_sched

Overview:
- Read-side scheduler for the double-buffered camera input frame buffer (480x272 RGB565, stored as RGB888 on readout), in the 100 MHz CNN/window domain.
- Owns the read-bank pointer and swaps banks on completed camera frames. Swaps are deferred while the CNN is consuming a frame.
- Shares the single BRAM read port between LCD scanout (priority, with anti-starvation for the CNN) and CNN window fetch. Issues the CNN start pulse.

Parameters:
- ADDR_W, 17, pixel address width.
- DATA_W, 24, read data width (RGB888).
- FRAME_PIXELS, 130560, valid address range is 0..FRAME_PIXELS-1.
- RD_LAT, 1, BRAM read latency in cycles (1..3).
- STARVE_MAX, 3, consecutive CNN denials before the CNN is forced a grant.

Ports:
- i_clk  in  1  100 MHz clock
- i_rst_n  in  1  synchronous active-low reset
- i_frame_done  in  1  one-cycle pulse, already synchronized into i_clk; the write bank holds a complete frame
- i_lcd_req  in  1  LCD read request
- i_lcd_addr  in  ADDR_W  LCD pixel address
- o_lcd_gnt  out  1  LCD request accepted this cycle (combinational)
- o_lcd_rvalid  out  1  o_rd_data belongs to the LCD
- i_cnn_req  in  1  CNN read request
- i_cnn_addr  in  ADDR_W  CNN pixel address
- o_cnn_gnt  out  1  CNN request accepted this cycle (combinational)
- o_cnn_rvalid  out  1  o_rd_data belongs to the CNN
- i_cnn_done  in  1  pulse: CNN finished the current frame
- o_start  out  1  one-cycle pulse: new frame available to the CNN
- o_mem_en  out  1  BRAM read enable
- o_mem_addr  out  ADDR_W  BRAM read address
- o_rd_bank  out  1  bank being read; the camera writes ~o_rd_bank
- i_mem_rdata  in  DATA_W  BRAM read data
- o_rd_data  out  DATA_W  returned data; 0 for erroneous reads
- o_drop_cnt  out  8  frames overwritten before being swapped in; saturates at 255
- o_addr_err  out  1  sticky: a granted address was >= FRAME_PIXELS

Behaviour:
- Reset values:
  - state S_IDLE, o_rd_bank=0, swap_pending=0, starve_cnt=0.
  - o_start=0, o_drop_cnt=0, o_addr_err=0.
  - Return pipeline flushed, so all rvalid=0 and o_rd_data=0.
- A reset asserted mid-operation discards in-flight reads; no rvalid is emitted for them.
- FSM states: S_IDLE, S_DRAIN, S_SWAP, S_RUN.
  - S_IDLE: grants allowed. If swap_pending=1, go to S_DRAIN and load drain_cnt=RD_LAT.
  - S_DRAIN: no grants. Decrement drain_cnt; at 0 go to S_SWAP. Drain is not re-checked; RD_LAT cycles always suffice.
  - S_SWAP: no grants. Toggle o_rd_bank, clear swap_pending, go to S_RUN. o_start is registered and is high in the first S_RUN cycle.
  - S_RUN: grants allowed. i_cnn_done goes to S_IDLE. i_frame_done only sets swap_pending; the bank never changes during S_RUN.
- swap_pending handling:
  - i_frame_done sets swap_pending in any state.
  - If swap_pending is already 1 and S_SWAP is not clearing it this cycle, o_drop_cnt increments (saturating) and pending stays 1.
  - If i_frame_done arrives in S_SWAP, pending is set again (new pending frame).
- Simultaneous i_cnn_done and i_frame_done in S_RUN: go to S_IDLE with pending=1, then S_DRAIN on the next cycle.
- Arbitration (S_IDLE/S_RUN only):
  - Only LCD requests: LCD granted.
  - Only CNN requests: CNN granted.
  - Both request: LCD wins unless starve_cnt==STARVE_MAX, in which case the CNN wins.
  - starve_cnt increments on each CNN denial. It clears on a CNN grant or when i_cnn_req=0.
- Grant and memory access:
  - A granted request drives o_mem_en=1 and o_mem_addr=that address combinationally.
  - If addr >= FRAME_PIXELS: the grant is still given, o_mem_en=0, o_addr_err is set (sticky until reset), and the entry is marked err.
- Return path:
  - An RD_LAT-deep shift register carries {valid, owner, err}.
  - RD_LAT cycles after the grant, exactly one of o_lcd_rvalid/o_cnn_rvalid pulses.
  - o_rd_data = err ? 0 : i_mem_rdata, presented in the same cycle as the rvalid.
- Requesters hold req/addr until granted. A request dropped before its grant is lost without error.

Decomposition:
- Shared package inbuf_pkg:
  - IMG_W=480, IMG_H=272, FRAME_PIXELS, ADDR_W.
  - FSM state encoding.
  - Owner encoding (OWN_LCD=0, OWN_CNN=1).
- One sub-module, inbuf_rd_arb: the 2-requester priority/anti-starvation arbiter (req, starve_cnt, block → gnt).
- FSM, bank pointer, and return pipeline stay in the top level.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with requests active. Expect o_rd_bank=0, o_start=0, o_drop_cnt=0, no gnt/rvalid, o_addr_err=0.
- First frame: i_frame_done pulse at cycle N in S_IDLE (RD_LAT=1). Expect:
  - S_DRAIN at N+1, S_SWAP at N+2.
  - o_rd_bank=1 and o_start=1 for exactly one cycle at N+3.
  - LCD requests at N+1..N+2 are not granted.
- Contention: both requests held continuously, STARVE_MAX=3, in S_RUN. Expect grant sequence L,L,L,C repeating. Each rvalid arrives 1 cycle after its grant, with owner matching and o_rd_data=i_mem_rdata.
- Deferred swap: in S_RUN, i_frame_done, then a second i_frame_done, then i_cnn_done. Expect:
  - o_rd_bank unchanged until after i_cnn_done.
  - o_drop_cnt=1.
  - Exactly one swap, with o_start 4 cycles after i_cnn_done.
- Address error: LCD addr=130560 granted. Expect o_mem_en=0, o_addr_err=1 (sticky), o_lcd_rvalid 1 cycle later with o_rd_data=0. The next in-range read returns memory data.
- Reset mid-drain: i_rst_n=0 during S_DRAIN. Expect o_rd_bank stays 0, no o_start, swap_pending cleared, and no rvalid for the read granted in the cycle before the drain.

Source files
------------

// File: rtl/inbuf_pkg.sv
// Shared constants and types for the camera input-buffer read side.
// Frame geometry, scheduler state encoding and return-path tag layout.
package inbuf_pkg;

  localparam int IMG_W        = 480;
  localparam int IMG_H        = 272;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int ADDR_W       = 17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWAP  = 2'd2,
    S_RUN   = 2'd3
  } rd_state_e;

  localparam logic OWN_LCD = 1'b0;
  localparam logic OWN_CNN = 1'b1;

  typedef struct packed {
    logic vld;
    logic own;
    logic err;
  } rd_tag_t;

endpackage

// File: rtl/inbuf_rd_arb.sv
// Two-requester read-port arbiter: LCD has priority, CNN is forced through after STARVE_MAX denials.
// Purely combinational; i_block suppresses every grant.
module inbuf_rd_arb #(
  parameter int STV_W      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic             i_lcd_req,
  input  logic             i_cnn_req,
  input  logic             i_block,
  input  logic [STV_W-1:0] i_starve_cnt,
  output logic             o_lcd_gnt,
  output logic             o_cnn_gnt
);

  logic force_cnn;

  always_comb begin
    force_cnn = (i_starve_cnt == STV_W'(STARVE_MAX));
    o_cnn_gnt = !i_block && i_cnn_req && (!i_lcd_req || force_cnn);
    o_lcd_gnt = !i_block && i_lcd_req && !(i_cnn_req && force_cnn);
  end

endmodule

// File: rtl/inbuf_rd_sched.sv
// Read-side scheduler for the double-buffered frame store: bank swap FSM, shared BRAM port arbitration, CNN start.
// Grants are same-cycle; data returns RD_LAT cycles later; requesters hold req/addr until granted.
module inbuf_rd_sched #(
  parameter int ADDR_W       = inbuf_pkg::ADDR_W,
  parameter int DATA_W       = 24,
  parameter int FRAME_PIXELS = inbuf_pkg::FRAME_PIXELS,
  parameter int RD_LAT       = 1,
  parameter int STARVE_MAX   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_done,
  input  logic              i_lcd_req,
  input  logic [ADDR_W-1:0] i_lcd_addr,
  output logic              o_lcd_gnt,
  output logic              o_lcd_rvalid,
  input  logic              i_cnn_req,
  input  logic [ADDR_W-1:0] i_cnn_addr,
  output logic              o_cnn_gnt,
  output logic              o_cnn_rvalid,
  input  logic              i_cnn_done,
  output logic              o_start,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_rd_bank,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [7:0]        o_drop_cnt,
  output logic              o_addr_err
);
  import inbuf_pkg::*;

  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  rd_state_e         state_q, state_d;
  logic              bank_q, bank_d, pend_q, pend_d, start_q, start_d, err_q, err_d;
  logic [1:0]        drain_q, drain_d;
  logic [7:0]        drop_q, drop_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              grant_en, lcd_gnt, cnn_gnt, any_gnt, bad_addr;
  logic [ADDR_W-1:0] gnt_addr;
  rd_tag_t           tag_in, tag_out;
  rd_tag_t           pipe_q [RD_LAT];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Entering S_IDLE with a frame already waiting drains immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pend_q || i_frame_done) state_d = S_DRAIN;
      S_DRAIN: if (drain_q <= 2'd1)        state_d = S_SWAP;
      S_SWAP:                              state_d = S_RUN;
      S_RUN:   if (i_cnn_done)             state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_en = i_rst_n && (state_q == S_IDLE || state_q == S_RUN);
  end

  inbuf_rd_arb #(
    .STV_W      (STV_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .i_lcd_req    (i_lcd_req),
    .i_cnn_req    (i_cnn_req),
    .i_block      (!grant_en),
    .i_starve_cnt (starve_q),
    .o_lcd_gnt    (lcd_gnt),
    .o_cnn_gnt    (cnn_gnt)
  );

  always_comb begin
    any_gnt  = lcd_gnt || cnn_gnt;
    gnt_addr = cnn_gnt ? i_cnn_addr : i_lcd_addr;
    bad_addr = any_gnt && (32'(gnt_addr) >= 32'(FRAME_PIXELS));
    tag_in.vld = any_gnt;
    tag_in.own = cnn_gnt ? OWN_CNN : OWN_LCD;
    tag_in.err = bad_addr;
  end

  always_comb begin
    drain_d = drain_q;
    if (state_q == S_IDLE)                        drain_d = 2'(RD_LAT);
    else if (state_q == S_DRAIN && drain_q != '0) drain_d = drain_q - 2'd1;
    bank_d  = bank_q ^ (state_q == S_SWAP);
    start_d = (state_q == S_SWAP);
    err_d   = err_q || bad_addr;
    pend_d  = pend_q && (state_q != S_SWAP);
    drop_d  = drop_q;
    // A frame arriving while another still waits overwrites it, unless the swap takes it this cycle.
    if (i_frame_done) begin
      pend_d = 1'b1;
      if (pend_q && state_q != S_SWAP && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    if (!i_cnn_req || cnn_gnt)               starve_d = '0;
    else if (starve_q != STV_W'(STARVE_MAX)) starve_d = starve_q + 1'b1;
    else                                     starve_d = starve_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      drain_q  <= '0;
      drop_q   <= '0;
      starve_q <= '0;
    end else begin
      bank_q   <= bank_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Return outputs are gated by reset so reads in flight when reset hits never surface.
  always_comb begin
    tag_out      = pipe_q[RD_LAT-1];
    o_lcd_rvalid = i_rst_n && tag_out.vld && (tag_out.own == OWN_LCD);
    o_cnn_rvalid = i_rst_n && tag_out.vld && (tag_out.own == OWN_CNN);
    o_rd_data    = (i_rst_n && tag_out.vld && !tag_out.err) ? i_mem_rdata : '0;
    o_lcd_gnt    = lcd_gnt;
    o_cnn_gnt    = cnn_gnt;
    o_mem_en     = any_gnt && !bad_addr;
    o_mem_addr   = gnt_addr;
    o_start      = start_q;
    o_rd_bank    = bank_q;
    o_drop_cnt   = drop_q;
    o_addr_err   = err_q;
  end

endmodule
